// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and zone helpers for the alarm blocks
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SET     = 2'b01,
        TRIGGER = 2'b10,
        ALERT   = 2'b11
    } fsm_state_t;

    localparam int MAX_ZONES = 16;

    function automatic logic [3:0] lowest_set(input logic [MAX_ZONES-1:0] v);
        lowest_set = '0;
        for (int i = MAX_ZONES - 1; i >= 0; i--)
            if (v[i]) lowest_set = 4'(i);
    endfunction

endpackage

// File: rtl/second_ticker.sv
// second_ticker: one-cycle pulse every CLK_HZ cycles, restartable from zero
module second_ticker #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clock,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    always_comb begin
        wrap   = cnt_q == CW'(CLK_HZ - 1);
        cnt_d  = (restart || wrap) ? '0 : cnt_q + 1'b1;
        tick_d = !restart && wrap;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/alarm_zone_controller.sv
// alarm_zone_controller: multi-zone IDLE/SET/TRIGGER/ALERT alarm sequencer
module alarm_zone_controller
    import alarm_pkg::*;
#(
    parameter int NUM_ZONES       = 4,
    parameter int CLK_HZ          = 50_000_000,
    parameter int ARM_DELAY_S     = 10,
    parameter int ENTRY_DELAY_S   = 15,
    parameter int ALERT_TIMEOUT_S = 0,
    parameter int TIMER_W         = 8,
    localparam int FZ_W           = NUM_ZONES > 1 ? $clog2(NUM_ZONES) : 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 arm_req,
    input  logic                 disarm_ok,
    input  logic [NUM_ZONES-1:0] zone_trip,
    input  logic [NUM_ZONES-1:0] zone_enable,
    input  logic [NUM_ZONES-1:0] zone_instant,
    output fsm_state_t           system_state,
    output logic                 armed,
    output logic [TIMER_W-1:0]   seconds_timer,
    output logic                 tick_1hz,
    output logic [NUM_ZONES-1:0] tripped_zones,
    output logic [FZ_W-1:0]      first_zone,
    output logic                 first_zone_valid
);

    localparam longint TMAX = (64'd1 << TIMER_W) - 1;
    localparam logic [TIMER_W-1:0] ARM_T   = TIMER_W'(ARM_DELAY_S);
    localparam logic [TIMER_W-1:0] ENTRY_T = TIMER_W'(ENTRY_DELAY_S);
    localparam logic [TIMER_W-1:0] ALERT_T = TIMER_W'(ALERT_TIMEOUT_S);

    if (NUM_ZONES < 1 || NUM_ZONES > MAX_ZONES ||
        ARM_DELAY_S < 0 || ARM_DELAY_S > TMAX ||
        ENTRY_DELAY_S < 0 || ENTRY_DELAY_S > TMAX ||
        ALERT_TIMEOUT_S < 0 || ALERT_TIMEOUT_S > TMAX) begin : g_bad_cfg
        $error("alarm_zone_controller: zone count or delay out of range");
    end

    fsm_state_t           state_q, state_d;
    logic [NUM_ZONES-1:0] s1_q, s2_q, qual;
    logic [NUM_ZONES-1:0] trz_q, trz_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [FZ_W-1:0]      fz_q, fz_d;
    logic                 armed_q, armed_d, fzv_q, fzv_d;
    logic                 trip, inst, tick, timer_zero, armed_trip;

    second_ticker #(.CLK_HZ(CLK_HZ)) u_ticker (
        .clock   (clock),
        .rst     (rst),
        .restart (state_d != state_q),
        .tick    (tick)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= IDLE;
            armed_q <= 1'b0;
            timer_q <= '0;
            trz_q   <= '0;
            fz_q    <= '0;
            fzv_q   <= 1'b0;
        end else begin
            s1_q    <= zone_trip;
            s2_q    <= s1_q;
            state_q <= state_d;
            armed_q <= armed_d;
            timer_q <= timer_d;
            trz_q   <= trz_d;
            fz_q    <= fz_d;
            fzv_q   <= fzv_d;
        end
    end

    always_comb begin
        qual       = s2_q & zone_enable;
        trip       = |qual;
        inst       = |(qual & zone_instant);
        timer_zero = timer_q == '0;
        armed_trip = state_q == SET && armed_q && trip;
        state_d    = state_q;
        case (state_q)
            IDLE:    state_d = arm_req ? SET : IDLE;
            SET:     state_d = armed_trip ? ((inst || ENTRY_DELAY_S == 0) ? ALERT : TRIGGER) : SET;
            TRIGGER: state_d = (inst || timer_zero) ? ALERT : TRIGGER;
            ALERT:   state_d = (ALERT_TIMEOUT_S != 0 && timer_zero) ? SET : ALERT;
            default: state_d = IDLE;
        endcase
        if (disarm_ok && state_q != IDLE) state_d = IDLE;
    end

    // Defaults cover staying in a state; the transition block then overrides on entry.
    always_comb begin
        timer_d = (tick && !timer_zero) ? timer_q - 1'b1 : timer_q;
        armed_d = armed_q || (state_q == SET && timer_zero);
        trz_d   = (state_q == IDLE || (state_q == SET && !armed_q)) ? trz_q : trz_q | qual;
        fz_d    = (armed_trip && !fzv_q) ? FZ_W'(lowest_set(MAX_ZONES'(qual))) : fz_q;
        fzv_d   = fzv_q || armed_trip;
        if (state_d != state_q) begin
            armed_d = state_d == SET && state_q == ALERT;
            timer_d = state_d == SET     ? (state_q == IDLE ? ARM_T : '0) :
                      state_d == TRIGGER ? ENTRY_T :
                      state_d == ALERT   ? ALERT_T : '0;
            if (state_d == SET && state_q == IDLE) begin
                trz_d = '0;
                fzv_d = 1'b0;
            end
            if (state_d == IDLE) begin
                trz_d = trz_q;
                fz_d  = fz_q;
                fzv_d = fzv_q;
            end
        end
    end

    always_comb begin
        system_state     = state_q;
        armed            = armed_q;
        seconds_timer    = timer_q;
        tick_1hz         = tick;
        tripped_zones    = trz_q;
        first_zone       = fz_q;
        first_zone_valid = fzv_q;
    end

endmodule

// File: tb/tb_alarm_zone_controller.sv
// tb_alarm_zone_controller: directed plus random checks of two controller builds
module tb_alarm_zone_controller;
    import alarm_pkg::*;

    localparam int CLK = 10;
    localparam int ARM = 3;
    localparam int ENT = 2;

    logic       clock = 1'b0, rst = 1'b1, arm_req = 1'b0, disarm_ok = 1'b0;
    logic [3:0] zone_trip = '0, zone_enable = '0, zone_instant = '0;

    fsm_state_t st0, st1;
    logic       armed0, armed1, tick0, tick1, fzv0, fzv1;
    logic [7:0] tmr0, tmr1;
    logic [3:0] trz0, trz1;
    logic [1:0] fz0, fz1;

    int n_chk = 0, n_fail = 0;

    int         m_state [2], m_age [2], m_load [2], m_fz [2];
    logic       m_armed [2], m_fzv [2];
    logic [3:0] m_trz [2];
    logic [3:0] h0 = '0, h1 = '0;

    always #5 clock = ~clock;

    alarm_zone_controller #(.NUM_ZONES(4), .CLK_HZ(CLK), .ARM_DELAY_S(ARM), .ENTRY_DELAY_S(ENT),
        .ALERT_TIMEOUT_S(0), .TIMER_W(8)) dut0 (
        .clock(clock), .rst(rst), .arm_req(arm_req), .disarm_ok(disarm_ok),
        .zone_trip(zone_trip), .zone_enable(zone_enable), .zone_instant(zone_instant),
        .system_state(st0), .armed(armed0), .seconds_timer(tmr0), .tick_1hz(tick0),
        .tripped_zones(trz0), .first_zone(fz0), .first_zone_valid(fzv0));

    alarm_zone_controller #(.NUM_ZONES(4), .CLK_HZ(CLK), .ARM_DELAY_S(ARM), .ENTRY_DELAY_S(ENT),
        .ALERT_TIMEOUT_S(2), .TIMER_W(8)) dut1 (
        .clock(clock), .rst(rst), .arm_req(arm_req), .disarm_ok(disarm_ok),
        .zone_trip(zone_trip), .zone_enable(zone_enable), .zone_instant(zone_instant),
        .system_state(st1), .armed(armed1), .seconds_timer(tmr1), .tick_1hz(tick1),
        .tripped_zones(trz1), .first_zone(fz1), .first_zone_valid(fzv1));

    // Seconds remaining as a function of time spent since the countdown was loaded.
    function automatic int timer_of(input int load, input int age);
        int t;
        if (age == 0) return load;
        t = load - (age - 1) / CLK;
        return t > 0 ? t : 0;
    endfunction

    function automatic int lowest(input logic [3:0] v);
        for (int j = 0; j < 4; j++) if (v[j]) return j;
        return 0;
    endfunction

    task automatic model_step();
        logic [3:0] qual;
        logic       inst;
        int         t, ns, nload, to;
        qual = h1 & zone_enable;
        inst = |(qual & zone_instant);
        for (int i = 0; i < 2; i++) begin
            to = (i == 0) ? 0 : 2;
            if (rst) begin
                m_state[i] = 0; m_age[i] = 0; m_load[i] = 0; m_fz[i] = 0;
                m_armed[i] = 1'b0; m_fzv[i] = 1'b0; m_trz[i] = '0;
                continue;
            end
            t = timer_of(m_load[i], m_age[i]);
            ns = m_state[i];
            nload = 0;
            if (m_state[i] != 0 && disarm_ok) begin
                ns = 0;
                m_armed[i] = 1'b0;
            end else begin
                case (m_state[i])
                    0: if (arm_req) begin
                        ns = 1; nload = ARM; m_armed[i] = 1'b0; m_trz[i] = '0; m_fzv[i] = 1'b0;
                    end
                    1: if (m_armed[i] && qual != 0) begin
                        m_trz[i] |= qual;
                        if (!m_fzv[i]) begin m_fz[i] = lowest(qual); m_fzv[i] = 1'b1; end
                        ns = (inst || ENT == 0) ? 3 : 2;
                        nload = (ns == 2) ? ENT : to;
                        m_armed[i] = 1'b0;
                    end else if (!m_armed[i] && t == 0) m_armed[i] = 1'b1;
                    2: begin
                        m_trz[i] |= qual;
                        if (inst || t == 0) begin ns = 3; nload = to; end
                    end
                    default: begin
                        m_trz[i] |= qual;
                        if (to != 0 && t == 0) begin ns = 1; nload = 0; m_armed[i] = 1'b1; end
                    end
                endcase
            end
            if (ns != m_state[i]) begin
                m_state[i] = ns; m_load[i] = nload; m_age[i] = 0;
            end else m_age[i]++;
        end
        if (rst) begin h0 = '0; h1 = '0; end
        else begin h1 = h0; h0 = zone_trip; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            string s;
            s = (i == 0) ? "dut0" : "dut1";
            chk({s, "_state"}, (i == 0) ? st0 : st1, m_state[i]);
            chk({s, "_armed"}, (i == 0) ? armed0 : armed1, m_armed[i]);
            chk({s, "_timer"}, (i == 0) ? tmr0 : tmr1, timer_of(m_load[i], m_age[i]));
            chk({s, "_tick"}, (i == 0) ? tick0 : tick1, m_age[i] > 0 && m_age[i] % CLK == 0);
            chk({s, "_tripped"}, (i == 0) ? trz0 : trz1, m_trz[i]);
            chk({s, "_first"}, (i == 0) ? fz0 : fz1, m_fz[i]);
            chk({s, "_first_valid"}, (i == 0) ? fzv0 : fzv1, m_fzv[i]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            compare_all();
        end
    endtask

    task automatic pulse_arm();
        arm_req = 1'b1; cyc(1); arm_req = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm_ok = 1'b1; cyc(1); disarm_ok = 1'b0;
    endtask

    task automatic wait_armed(input string tag, input int expect_n);
        int n;
        n = 0;
        while (!armed0 && n < 60) begin cyc(1); n++; end
        chk(tag, n, expect_n);
    endtask

    initial begin
        int n;
        zone_enable = 4'b1110; zone_instant = 4'b1000;
        cyc(3);
        chk("rst_state", st0, IDLE);
        chk("rst_armed", armed0, 0);
        chk("rst_timer", tmr0, 0);
        chk("rst_tick", tick0, 0);
        chk("rst_tripped", trz0, 0);
        chk("rst_first", fz0, 0);
        chk("rst_first_valid", fzv0, 0);
        rst = 1'b0;
        cyc(2);

        pulse_arm();
        chk("arm_state", st0, SET);
        chk("arm_timer3", tmr0, 3);
        chk("arm_exit_armed", armed0, 0);
        cyc(10); chk("exit_tick", tick0, 1); chk("exit_t3_hold", tmr0, 3);
        cyc(1);  chk("exit_t2", tmr0, 2);
        cyc(10); chk("exit_t1", tmr0, 1);
        cyc(10); chk("exit_t0", tmr0, 0); chk("exit_t0_not_armed", armed0, 0);
        cyc(1);  chk("armed_rise", armed0, 1);

        zone_trip = 4'b0100;
        cyc(2); chk("trip_latency_set", st0, SET);
        cyc(1); chk("trip_trigger", st0, TRIGGER); chk("entry_timer", tmr0, 2);
        zone_trip = 4'b0000;
        n = 0;
        while (st0 != ALERT && n < 60) begin cyc(1); n++; end
        chk("entry_delay_cycles", n, 22);
        chk("alert_tripped", trz0, 4'b0100);
        chk("alert_first", fz0, 2);
        chk("alert_first_valid", fzv0, 1);
        chk("to_alert", st1, ALERT);
        cyc(21); chk("to_still_alert", st1, ALERT); chk("latched_alert", st0, ALERT);
        cyc(1);
        chk("to_rearm_state", st1, SET);
        chk("to_rearm_armed", armed1, 1);
        chk("to_rearm_tripped", trz1, 4'b0100);

        pulse_disarm();
        chk("disarm_state", st0, IDLE);
        chk("disarm_timer", tmr0, 0);
        chk("disarm_keep_tripped", trz0, 4'b0100);
        chk("disarm_to_state", st1, IDLE);

        pulse_arm();
        wait_armed("arm_wait2", 32);
        zone_trip = 4'b0001;
        cyc(6); chk("disabled_zone", st0, SET); chk("disabled_tripped", trz0, 0);
        zone_trip = 4'b1001;
        cyc(2); chk("instant_latency", st0, SET);
        cyc(1);
        chk("instant_alert", st0, ALERT);
        chk("instant_tripped", trz0, 4'b1000);
        chk("instant_first", fz0, 3);
        zone_trip = 4'b0000;
        pulse_disarm();

        zone_instant = 4'b0000;
        pulse_arm();
        wait_armed("arm_wait3", 32);
        zone_trip = 4'b1010;
        cyc(3);
        chk("simul_state", st0, TRIGGER);
        chk("simul_first", fz0, 1);
        chk("simul_tripped", trz0, 4'b1010);
        zone_trip = 4'b0000;
        n = 0;
        while (tmr0 != 0 && n < 40) begin cyc(1); n++; end
        chk("entry_zero_cycles", n, 21);
        chk("pre_expiry_state", st0, TRIGGER);
        pulse_disarm();
        chk("prio_state", st0, IDLE);
        chk("prio_timer", tmr0, 0);
        chk("prio_tripped", trz0, 4'b1010);
        cyc(15);
        chk("idle_hold_tripped", trz0, 4'b1010);
        chk("idle_hold_first", fz0, 1);
        disarm_ok = 1'b1; cyc(1); disarm_ok = 1'b0;
        chk("idle_disarm_noop", st0, IDLE);

        pulse_arm();
        chk("rearm_clear_tripped", trz0, 0);
        chk("rearm_clear_valid", fzv0, 0);
        zone_trip = 4'b0010;
        cyc(5); chk("exit_trip_ignored", st0, SET);
        zone_trip = 4'b0000;
        wait_armed("arm_wait4", 27);
        cyc(5);
        chk("exit_trip_state", st0, SET);
        chk("exit_trip_tripped", trz0, 0);

        zone_trip = 4'b0010;
        cyc(3); chk("rst_pre_trigger", st0, TRIGGER);
        zone_trip = 4'b0000;
        n = 0;
        while (tmr0 != 1 && n < 40) begin cyc(1); n++; end
        chk("rst_wait_t1", n, 11);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_state", st0, IDLE);
        chk("mid_rst_timer", tmr0, 0);
        chk("mid_rst_tripped", trz0, 0);
        chk("mid_rst_first", fz0, 0);
        chk("mid_rst_valid", fzv0, 0);
        chk("mid_rst_tick", tick0, 0);
        arm_req = 1'b1;
        cyc(2); chk("arm_in_reset", st0, IDLE);
        arm_req = 1'b0; rst = 1'b0;
        cyc(2);

        zone_enable = 4'b1111;
        for (int k = 0; k < 3000; k++) begin
            arm_req   = $urandom_range(0, 15) == 0;
            disarm_ok = $urandom_range(0, 79) == 0;
            rst       = $urandom_range(0, 999) == 0;
            if ($urandom_range(0, 24) == 0) zone_trip = 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                zone_enable  = 4'($urandom);
                zone_instant = 4'($urandom);
            end
            cyc(1);
        end
        arm_req = 1'b0; disarm_ok = 1'b0; rst = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
